// File: rtl/ifetch_unit.sv
// ifetch_unit: fetch initiator with one in-flight request, instruction FIFO and redirect flush.
// Define IFETCH_ALIGN_CHECK_EN to halt on misaligned redirect targets instead of forcing alignment.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Start,
    output logic [31:0] PC,
    output logic        MemRead,
    input  logic [31:0] Instruction,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        InstrValid,
    input  logic        InstrReady,
    output logic [31:0] InstrOut,
    output logic [31:0] InstrPC,
    output logic        MisalignErr
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
    state_t      state;
    logic [31:0] buf_instr [8];
    logic [31:0] buf_pc [8];
    logic [2:0]  head;
    logic [2:0]  wptr;
    logic [3:0]  count;
    logic [3:0]  wsum;
    logic [4:0]  occ;
    logic        inflight;
    logic [31:0] inflight_pc;
    logic        misalign_err;
    logic        redir;
    logic        misalign;
    logic        pop;
    logic        push;
    logic [31:0] target;

`ifdef IFETCH_ALIGN_CHECK_EN
    assign misalign = RedirectPC[1:0] != 2'b00;
    assign target   = RedirectPC;
`else
    assign misalign = 1'b0;
    assign target   = RedirectPC & ~32'h3;
`endif

    assign redir       = Redirect && state != HALT;
    assign InstrValid  = count != 4'd0;
    assign InstrOut    = buf_instr[head];
    assign InstrPC     = buf_pc[head];
    assign MisalignErr = misalign_err;
    assign pop         = InstrValid && InstrReady && !redir;
    // A captured response is dropped when a redirect lands on the same edge
    assign push        = inflight && !redir;
    assign occ         = {1'b0, count} + {4'b0, inflight} - {4'b0, pop};
    assign MemRead     = state == RUN && !Redirect && occ < 5'(FIFO_DEPTH);
    assign wsum        = {1'b0, head} + count;
    assign wptr        = 3'(wsum >= 4'(FIFO_DEPTH) ? wsum - 4'(FIFO_DEPTH) : wsum);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            PC           <= RESET_PC;
            inflight     <= 1'b0;
            inflight_pc  <= 32'h0;
            head         <= 3'd0;
            count        <= 4'd0;
            misalign_err <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                buf_instr[i] <= 32'h0;
                buf_pc[i]    <= 32'h0;
            end
        end else begin
            inflight <= MemRead;
            if (MemRead) begin
                inflight_pc <= PC;
                PC          <= PC + 32'd4;
            end
            if (state == IDLE && Start) state <= RUN;
            if (redir) begin
                head  <= 3'd0;
                count <= 4'd0;
                if (misalign) begin
                    state        <= HALT;
                    misalign_err <= 1'b1;
                end else PC <= target;
            end else begin
                if (push) begin
                    buf_instr[wptr] <= Instruction;
                    buf_pc[wptr]    <= inflight_pc;
                end
                if (pop) head <= head == 3'(FIFO_DEPTH - 1) ? 3'd0 : head + 3'd1;
                count <= count + {3'b0, push} - {3'b0, pop};
            end
        end
    end
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed timing checks plus randomized ready/redirect traffic scored
// against an address-stream model (consecutive words from the last redirect target).
module tb_ifetch_unit;
    localparam logic [31:0] K = 32'hA5A5_A5A5;
    logic        CLK = 1'b0, RST = 1'b1, Start = 1'b0, Redirect = 1'b0, InstrReady = 1'b0;
    logic [31:0] RedirectPC = 32'h0, Instruction = 32'h0;
    logic [31:0] PC, InstrOut, InstrPC;
    logic        MemRead, InstrValid, MisalignErr;
    int          tests = 0, fails = 0;

    ifetch_unit dut (
        .CLK(CLK), .RST(RST), .Start(Start), .PC(PC), .MemRead(MemRead),
        .Instruction(Instruction), .Redirect(Redirect), .RedirectPC(RedirectPC),
        .InstrValid(InstrValid), .InstrReady(InstrReady), .InstrOut(InstrOut),
        .InstrPC(InstrPC), .MisalignErr(MisalignErr)
    );

    always #5 CLK = ~CLK;

    // Instruction memory: word at addr is addr^K, valid the cycle after the request
    always @(posedge CLK) Instruction <= MemRead ? (PC ^ K) : 32'hDEAD_BEEF;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; Start = 1'b0; Redirect = 1'b0; InstrReady = 1'b0;
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (PC !== 32'h0) begin fails++; $display("FAIL reset_pc got %h want 00000000", PC); end
        tests++; if (MemRead !== 1'b0) begin fails++; $display("FAIL reset_memread got %b want 0", MemRead); end
        tests++; if (InstrValid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", InstrValid); end
        tests++; if (InstrOut !== 32'h0 || InstrPC !== 32'h0) begin fails++; $display("FAIL reset_out got %h/%h want 0/0", InstrOut, InstrPC); end
        tests++; if (MisalignErr !== 1'b0) begin fails++; $display("FAIL reset_misalign got %b want 0", MisalignErr); end
        tick();
        tests++; if (MemRead !== 1'b0) begin fails++; $display("FAIL idle_memread got %b want 0", MemRead); end
    endtask

    task automatic test_first_fetch();
        do_reset();
        InstrReady = 1'b1; Start = 1'b1;
        tick();
        Start = 1'b0;
        tests++; if (MemRead !== 1'b1 || PC !== 32'h0) begin fails++; $display("FAIL first_issue got %b@%h want 1@00000000", MemRead, PC); end
        tests++; if (InstrValid !== 1'b0) begin fails++; $display("FAIL first_s1_valid got %b want 0", InstrValid); end
        tick();
        tests++; if (InstrValid !== 1'b0) begin fails++; $display("FAIL first_s2_valid got %b want 0", InstrValid); end
        tick();
        for (int i = 0; i < 7; i++) begin
            tests++;
            if (InstrValid !== 1'b1 || InstrPC !== 32'(4 * i) || InstrOut !== (32'(4 * i) ^ K)) begin
                fails++; $display("FAIL stream_%0d got v=%b pc=%h d=%h want v=1 pc=%h d=%h", i, InstrValid, InstrPC, InstrOut, 32'(4 * i), 32'(4 * i) ^ K);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            tests++;
            if (MemRead !== 1'b0 || InstrValid !== 1'b1 || InstrPC !== 32'h0 || InstrOut !== K) begin
                fails++; $display("FAIL bp_hold_%0d got mr=%b v=%b pc=%h d=%h want mr=0 v=1 pc=0 d=%h", i, MemRead, InstrValid, InstrPC, InstrOut, K);
            end
            tick();
        end
        InstrReady = 1'b1;
        #1;
        tests++; if (MemRead !== 1'b1 || PC !== 32'h8) begin fails++; $display("FAIL bp_resume got %b@%h want 1@00000008", MemRead, PC); end
        for (int i = 1; i < 5; i++) begin
            tick();
            tests++;
            if (InstrValid !== 1'b1 || InstrPC !== 32'(4 * i) || InstrOut !== (32'(4 * i) ^ K)) begin
                fails++; $display("FAIL bp_release_%0d got v=%b pc=%h want v=1 pc=%h", i, InstrValid, InstrPC, 32'(4 * i));
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        tick();
        Redirect = 1'b1; RedirectPC = 32'h0000_0100;
        #1;
        tests++; if (MemRead !== 1'b0) begin fails++; $display("FAIL redir_memread got %b want 0", MemRead); end
        tick();
        Redirect = 1'b0; InstrReady = 1'b1;
        #1;
        tests++; if (InstrValid !== 1'b0 || MemRead !== 1'b1 || PC !== 32'h100) begin fails++; $display("FAIL redir_r1 got v=%b mr=%b pc=%h want v=0 mr=1 pc=00000100", InstrValid, MemRead, PC); end
        tick();
        tests++; if (InstrValid !== 1'b0) begin fails++; $display("FAIL redir_r2_valid got %b want 0", InstrValid); end
        tick();
        tests++; if (InstrValid !== 1'b1 || InstrPC !== 32'h100 || InstrOut !== (32'h100 ^ K)) begin fails++; $display("FAIL redir_target got v=%b pc=%h d=%h want v=1 pc=00000100", InstrValid, InstrPC, InstrOut); end
        tick();
        tests++; if (InstrValid !== 1'b1 || InstrPC !== 32'h104) begin fails++; $display("FAIL redir_next got v=%b pc=%h want v=1 pc=00000104", InstrValid, InstrPC); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp [3];
        exp[0] = 32'hFFFF_FFF8; exp[1] = 32'hFFFF_FFFC; exp[2] = 32'h0000_0000;
        do_reset();
        InstrReady = 1'b1; Start = 1'b1; Redirect = 1'b1; RedirectPC = 32'hFFFF_FFF8;
        tick();
        Start = 1'b0; Redirect = 1'b0;
        #1;
        tests++; if (MemRead !== 1'b1 || PC !== 32'hFFFF_FFF8) begin fails++; $display("FAIL wrap_issue got %b@%h want 1@fffffff8", MemRead, PC); end
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (InstrValid !== 1'b1 || InstrPC !== exp[i] || InstrOut !== (exp[i] ^ K)) begin
                fails++; $display("FAIL wrap_%0d got v=%b pc=%h want v=1 pc=%h", i, InstrValid, InstrPC, exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_misalign();
        do_reset();
        InstrReady = 1'b1; Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        tick();
        Redirect = 1'b1; RedirectPC = 32'h0000_0102;
        tick();
        Redirect = 1'b0;
        #1;
`ifdef IFETCH_ALIGN_CHECK_EN
        for (int i = 0; i < 10; i++) begin
            tests++;
            if (MisalignErr !== 1'b1 || MemRead !== 1'b0 || InstrValid !== 1'b0 || PC !== 32'h8) begin
                fails++; $display("FAIL halt_%0d got err=%b mr=%b v=%b pc=%h want err=1 mr=0 v=0 pc=00000008", i, MisalignErr, MemRead, InstrValid, PC);
            end
            tick();
        end
        Redirect = 1'b1; RedirectPC = 32'h0000_0200;
        tick();
        Redirect = 1'b0;
        #1;
        tests++; if (PC !== 32'h8 || MemRead !== 1'b0 || MisalignErr !== 1'b1) begin fails++; $display("FAIL halt_redirect got pc=%h mr=%b err=%b want pc=00000008 mr=0 err=1", PC, MemRead, MisalignErr); end
`else
        tests++; if (MemRead !== 1'b1 || PC !== 32'h100 || MisalignErr !== 1'b0) begin fails++; $display("FAIL align_issue got mr=%b pc=%h err=%b want mr=1 pc=00000100 err=0", MemRead, PC, MisalignErr); end
        tick();
        tick();
        tests++; if (InstrValid !== 1'b1 || InstrPC !== 32'h100 || InstrOut !== (32'h100 ^ K)) begin fails++; $display("FAIL align_target got v=%b pc=%h want v=1 pc=00000100", InstrValid, InstrPC); end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        InstrReady = 1'b1; Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        tests++;
        if (PC !== 32'h0 || MemRead !== 1'b0 || InstrValid !== 1'b0 || InstrOut !== 32'h0 || InstrPC !== 32'h0 || MisalignErr !== 1'b0) begin
            fails++; $display("FAIL rst_mid got pc=%h mr=%b v=%b d=%h ipc=%h err=%b want all zero", PC, MemRead, InstrValid, InstrOut, InstrPC, MisalignErr);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (InstrValid !== 1'b0 || MemRead !== 1'b0) begin fails++; $display("FAIL rst_drop_%0d got v=%b mr=%b want 0/0", i, InstrValid, MemRead); end
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        int pops;
        pops = 0;
        exp_pc = 32'h0;
        do_reset();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int c = 0; c < 600; c++) begin
            InstrReady = $urandom_range(0, 3) != 0;
            Redirect   = $urandom_range(0, 24) == 0;
            RedirectPC = {22'h0, 8'($urandom), 2'b00};
            #1;
            if (Redirect) begin
                tests++; if (MemRead !== 1'b0) begin fails++; $display("FAIL rand_redir_mr c=%0d got %b want 0", c, MemRead); end
                exp_pc = RedirectPC;
            end else if (InstrValid && InstrReady) begin
                tests++;
                if (InstrPC !== exp_pc || InstrOut !== (exp_pc ^ K)) begin
                    fails++; $display("FAIL rand_pop c=%0d got pc=%h d=%h want pc=%h d=%h", c, InstrPC, InstrOut, exp_pc, exp_pc ^ K);
                end
                exp_pc += 32'd4;
                pops++;
            end
            tick();
        end
        Redirect = 1'b0;
        tests++; if (pops < 100) begin fails++; $display("FAIL rand_progress got %0d pops want >=100", pops); end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_misalign();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
